// File: rtl/operand_skew_feeder.sv
// Turns one accepted operand vector per cycle into a diagonal wavefront for the systolic array.
// Latency 1+i cycles on lane i; in_ready drops for LANES cycles after each tile while the wavefront drains.
module operand_skew_feeder #(
  parameter int LANES      = 4,
  parameter int DATA_SIZE  = 16,
  parameter int TILE_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LANES*DATA_SIZE-1:0]        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [LANES-1:0][DATA_SIZE-1:0]   out_data,
  output logic [LANES-1:0]                  out_valid,
  output logic                              tile_done
);

  localparam int ACW = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;
  localparam int DCW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ACW-1:0] ACC_LAST   = ACW'(TILE_DEPTH - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LANES - 1);

  typedef enum logic {S_STREAM, S_DRAIN} state_t;

  state_t           r_state;
  logic [ACW-1:0]   r_acc_cnt;
  logic [DCW-1:0]   r_drain_cnt;
  logic             r_in_ready;
  logic             r_tile_done;
  logic             w_accept;

  assign w_accept  = in_valid && r_in_ready;
  assign in_ready  = r_in_ready;
  assign tile_done = r_tile_done;

  // tile_done is registered one step early so it lands with the last element on the final lane
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_STREAM;
      r_acc_cnt   <= '0;
      r_drain_cnt <= '0;
      r_in_ready  <= 1'b1;
      r_tile_done <= 1'b0;
    end else begin
      case (r_state)
        S_STREAM: begin
          r_tile_done <= 1'b0;
          if (w_accept) begin
            if (r_acc_cnt == ACC_LAST) begin
              r_acc_cnt   <= '0;
              r_drain_cnt <= '0;
              r_state     <= S_DRAIN;
              r_in_ready  <= 1'b0;
              r_tile_done <= (DRAIN_LAST == '0);
            end else begin
              r_acc_cnt <= r_acc_cnt + ACW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state     <= S_STREAM;
            r_drain_cnt <= '0;
            r_in_ready  <= 1'b1;
            r_tile_done <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
            r_tile_done <= ((r_drain_cnt + DCW'(1)) == DRAIN_LAST);
          end
        end
        default: r_state <= S_STREAM;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [g:0]                 r_vld;
    logic [g:0][DATA_SIZE-1:0]  r_dat;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld <= '0;
        r_dat <= '0;
      end else begin
        r_vld[0] <= w_accept;
        r_dat[0] <= w_accept ? in_data[g*DATA_SIZE +: DATA_SIZE] : '0;
        for (int j = 1; j <= g; j++) begin
          r_vld[j] <= r_vld[j-1];
          r_dat[j] <= r_dat[j-1];
        end
      end
    end

    assign out_valid[g] = r_vld[g];
    assign out_data[g]  = r_dat[g];
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder: 4-lane and 1-lane builds, scoreboard keyed by arrival edge.
module tb_operand_skew_feeder;

  typedef struct packed {
    int          t;
    logic [15:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [63:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][15:0] out_data;
  logic [3:0]       out_valid;
  logic             tile_done;

  logic [15:0]      in_data1;
  logic             in_valid1;
  logic             in_ready1;
  logic [0:0][15:0] out_data1;
  logic [0:0]       out_valid1;
  logic             tile_done1;

  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   tb_acc = 0;
  int   tb_acc1 = 0;
  logic mon_en = 1'b0;

  exp_t q [4][$];
  exp_t q1 [$];
  int   td [$];
  int   td1 [$];

  operand_skew_feeder #(.LANES(4), .DATA_SIZE(16), .TILE_DEPTH(3)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .tile_done(tile_done)
  );

  operand_skew_feeder #(.LANES(1), .DATA_SIZE(16), .TILE_DEPTH(3)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .tile_done(tile_done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] b);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = {b, 8'(i)};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive a vector that must be accepted on the coming edge and record where each lane should show it.
  task automatic accept(input logic [7:0] b);
    exp_t e;
    chk("in_ready_at_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = pack(b);
    for (int i = 0; i < 4; i++) begin
      e.t = edge_n + i + 1;
      e.d = {b, 8'(i)};
      q[i].push_back(e);
    end
    tb_acc++;
    if (tb_acc == 3) begin
      td.push_back(edge_n + 4);
      tb_acc = 0;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_wait();
    repeat (4) begin
      chk("in_ready_drain", in_ready, 1'b0);
      step();
    end
  endtask

  task automatic accept1(input logic [15:0] d);
    exp_t e;
    chk("in_ready1_at_accept", in_ready1, 1'b1);
    in_valid1 = 1'b1;
    in_data1  = d;
    e.t = edge_n + 1;
    e.d = d;
    q1.push_back(e);
    tb_acc1++;
    if (tb_acc1 == 3) begin
      td1.push_back(edge_n + 1);
      tb_acc1 = 0;
    end
    step();
    in_valid1 = 1'b0;
  endtask

  exp_t m_e;
  logic m_expv;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        m_expv = (q[i].size() > 0) && (q[i][0].t == edge_n);
        chk($sformatf("lane%0d_valid@%0d", i, edge_n), out_valid[i], m_expv);
        if (m_expv) begin
          m_e = q[i].pop_front();
          chk($sformatf("lane%0d_data@%0d", i, edge_n), out_data[i], m_e.d);
        end else begin
          chk($sformatf("lane%0d_zero@%0d", i, edge_n), out_data[i], 32'h0);
        end
      end
      m_expv = (td.size() > 0) && (td[0] == edge_n);
      chk($sformatf("tile_done@%0d", edge_n), tile_done, m_expv);
      if (m_expv) void'(td.pop_front());

      m_expv = (q1.size() > 0) && (q1[0].t == edge_n);
      chk($sformatf("l1_valid@%0d", edge_n), out_valid1[0], m_expv);
      if (m_expv) begin
        m_e = q1.pop_front();
        chk($sformatf("l1_data@%0d", edge_n), out_data1[0], m_e.d);
      end else begin
        chk($sformatf("l1_zero@%0d", edge_n), out_data1[0], 32'h0);
      end
      m_expv = (td1.size() > 0) && (td1[0] == edge_n);
      chk($sformatf("l1_tile_done@%0d", edge_n), tile_done1, m_expv);
      if (m_expv) void'(td1.pop_front());
    end
  end

  initial begin
    // Reset held two cycles with a valid all-ones vector offered on both builds
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = '1;
    in_valid1 = 1'b1;
    in_data1  = '1;
    step();
    mon_en = 1'b1;
    step();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    chk("in_ready_after_reset", in_ready, 1'b1);
    chk("in_ready1_after_reset", in_ready1, 1'b1);

    // Back-to-back tile
    accept(8'h0A);
    accept(8'h0B);
    accept(8'h0C);
    drain_wait();

    // Bubble inside a tile
    accept(8'h1A);
    step();
    accept(8'h1B);
    accept(8'h1C);
    drain_wait();

    // Vector D held valid through DRAIN, then it opens the next tile
    accept(8'h2A);
    accept(8'h2B);
    accept(8'h2C);
    in_valid = 1'b1;
    in_data  = pack(8'h2D);
    drain_wait();
    accept(8'h2D);
    accept(8'h2E);
    accept(8'h2F);
    drain_wait();

    // Reset one cycle into DRAIN aborts the tile without a tile_done
    accept(8'h3A);
    accept(8'h3B);
    accept(8'h3C);
    chk("in_ready_drain_pre_reset", in_ready, 1'b0);
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) q[i].delete();
    td.delete();
    tb_acc = 0;
    reset = 1'b0;
    chk("in_ready_after_mid_reset", in_ready, 1'b1);
    accept(8'h4A);
    accept(8'h4B);
    accept(8'h4C);
    drain_wait();

    // Single-lane build
    accept1(16'h5A00);
    accept1(16'h5B00);
    accept1(16'h5C00);
    chk("in_ready1_drain", in_ready1, 1'b0);
    step();
    chk("in_ready1_back", in_ready1, 1'b1);

    repeat (8) step();
    for (int i = 0; i < 4; i++) chk($sformatf("lane%0d_q_left", i), q[i].size(), 0);
    chk("td_q_left", td.size(), 0);
    chk("l1_q_left", q1.size(), 0);
    chk("td1_q_left", td1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
# operand_skew_feeder

Front-end stage of the MXU systolic array. Accepts one operand vector per cycle (LANES elements) through a valid/ready handshake and presents it to the array as a diagonal wavefront: lane i is delayed i cycles more than lane 0. Vectors are grouped into tiles of TILE_DEPTH. After the last vector of a tile is accepted, the block stops accepting input until the wavefront has fully drained, then pulses `tile_done`. Its lane outputs feed the array edge and the per-row FifoBuffer delay lines directly.

## Interface
- `LANES`, default 4: number of lanes (array rows); must be ≥1.
- `DATA_SIZE`, default FSIZE: element width in bits.
- `TILE_DEPTH`, default 8: vectors per tile; must be ≥1.

- `clk`  in  1: single clock; everything is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  LANES*DATA_SIZE: lane i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block can accept a vector. A vector is accepted on an edge where `in_valid && in_ready`.
- `out_data`  out  LANES×DATA_SIZE (packed [LANES-1:0][DATA_SIZE-1:0]): skewed lane elements.
- `out_valid`  out  LANES: per-lane valid.
- `tile_done`  out  1: one-cycle pulse when the last element of a tile leaves lane LANES-1.

## Operation
- State machine, IDLE/STREAM → DRAIN → IDLE:
  - **IDLE/STREAM** (`in_ready`=1): accept vectors and count them with `acc_cnt` (0..TILE_DEPTH-1). On the accept that brings the count to TILE_DEPTH, reset `acc_cnt` to 0 and enter DRAIN.
  - **DRAIN** (`in_ready`=0): `drain_cnt` runs 0..LANES-1, one step per cycle. In the cycle where `drain_cnt`==LANES-1, `tile_done`=1. The next edge returns to IDLE.
- Skew path:
  - Lane i is a chain of i+1 registers, each carrying {valid, data}.
  - Stage 0 loads {accept, accept ? lane data : 0}.
  - Each following stage copies the previous stage unconditionally, every cycle, including during DRAIN.
- Zero fill: when a lane is not valid, its `out_data` is 0. The datapath never holds stale data.
- Bubbles: cycles with no accept during IDLE/STREAM enter stage 0 as invalid/zero. The bubble appears on every lane at the same relative position, so diagonal alignment is preserved.
- A tile never straddles DRAIN. Input arriving during DRAIN is held off by `in_ready`=0. `in_valid` may stay high; that vector is accepted on the first edge back in IDLE.
- `acc_cnt` persists across bubbles; a tile ends only after TILE_DEPTH accepts.
- Reset at any point, including mid-tile or mid-DRAIN:
  - The next cycle shows all lane registers cleared, state IDLE, and both counters at 0.
  - Any partial tile is discarded.
  - `tile_done` does not pulse for the aborted tile.
- Reset values: `out_data`=0, `out_valid`=0, `tile_done`=0, `in_ready`=1.

## Timing
- For a vector accepted on edge k, lane i is presented in the cycle after edge k+i. Latency is 1+i cycles.
- Last accept of a tile on edge k:
  - DRAIN occupies the LANES cycles following edges k … k+LANES-1.
  - `tile_done` is high in the cycle after edge k+LANES-1, coincident with `out_valid[LANES-1]` for the final vector.
  - `in_ready` returns to 1 after edge k+LANES.
- Throughput: TILE_DEPTH vectors per TILE_DEPTH+LANES cycles with no bubbles.
- LANES=1: DRAIN is 1 cycle, and `tile_done` coincides with lane 0's last output.
- `in_ready` is a registered-state decode. It has no combinational path from `in_valid`.

## Test plan
Configuration for all scenarios: LANES=4, TILE_DEPTH=3, DATA_SIZE=16.

1. **Reset.** Hold `reset` for 2 cycles with `in_valid`=1, `in_data`=0xFFFF… → in those cycles `out_valid`=0, `out_data`=0, `tile_done`=0. `in_ready`=1 after release. No vector is accepted while `reset`=1.
2. **Back-to-back tile.** Vectors A, B, C, with lane i of A = 0x0A0i (similarly for B and C), accepted on edges 0, 1, 2 →
   - lane i shows 0x0A0i after edge i, 0x0B0i after edge i+1, 0x0C0i after edge i+2;
   - `in_ready`=0 after edges 2..5;
   - `tile_done`=1 only after edge 5;
   - `in_ready`=1 after edge 6.
3. **Bubble.** `in_valid` pattern 1,0,1,1 with vectors A, –, B, C →
   - lane i shows A, then one invalid/zero cycle, then B, C, with identical spacing on all lanes;
   - `tile_done` after edge 3+3.
4. **Held input across a tile boundary.** `in_valid` held high with a fourth vector D present throughout DRAIN →
   - D is accepted exactly once, on the first edge with `in_ready`=1 (edge 6 in scenario 2 timing);
   - D's lane 0 appears after edge 6 and is counted as tile 2, vector 0.
5. **Reset mid-DRAIN.** Assert `reset` for 1 cycle after edge 3 of scenario 2 →
   - next cycle: all `out_valid`=0, `out_data`=0, `in_ready`=1;
   - no `tile_done` ever pulses for that tile;
   - a following full tile completes normally with `tile_done` 3 cycles after its last accept.
6. **LANES=1 build.** Tile of 3 vectors →
   - each output follows its accept by 1 cycle;
   - `tile_done` coincides with the third output;
   - `in_ready` is low for exactly 1 cycle.
